decode_queue: RTL and testbench
===============================

# decode_queue

Buffered, pipelined successor to the combinational instruction decoder. It accepts fetched RV32I instructions and their PCs over a valid/ready handshake and stores them in a parametrised FIFO. It decodes the head entry and presents the decoded fields from a registered output stage, also under valid/ready. It sits between fetch and execute, absorbs fetch/execute rate mismatch, and supports pipeline flush on branch mispredict.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..32.
- EN_MEM, 1: 1 = decode LOAD/STORE/LUI/AUIPC; 0 = those opcodes decode as invalid.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all queued and output-stage instructions.
- inValid  in  1  fetch offers inInstruction/inPC.
- inReady  out  1  queue can accept; = !rst && !flush && (count < DEPTH).
- inInstruction  in  32  raw instruction.
- inPC  in  32  instruction address.
- outValid  out  1  decoded output-stage entry present.
- outReady  in  1  consumer takes the output this cycle.
- outPC, outInstruction  out  32 each  registered copies of the entry.
- opcode[6:0], rd/rs1/rs2[4:0], fun3[2:0], fun7[6:0], immediateValue[31:0]  out  decoded fields.
- enRegWrite, enALU, useImmediate, isBranch, isJump, isLoad, isStore  out  1 each  control.
- opALU  out  4  ALU operation.
- isRT, isIT, isBT, isJT, isVI  out  1 each  instruction class; isVI = valid opcode.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy, excluding the output stage.

## Operation
- Push when inValid && inReady: write {inInstruction, inPC} at wrPtr; wrPtr+1 modulo DEPTH.
- Load the output stage when count != 0 && (!outValid || outReady) && !flush: decode the head entry into all output registers, set outValid=1, rdPtr+1 modulo DEPTH.
- If outValid && outReady and nothing is loaded, outValid becomes 0.
- Push and load may occur in the same cycle; count is unchanged.
- A full queue does not accept even if a pop occurs the same cycle; there is no pass-through.
- flush: next edge sets count=0, wrPtr=rdPtr=0, outValid=0. Flush wins over push and load.
- Decode rules:
  - R (0110011): ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001. SUB/SRA are selected by fun7=0100000.
  - I-ALU (0010011): same opALU by fun3; SRAI is selected by fun7. useImmediate=1. Immediate is sign-extended [31:20].
  - B (1100011): enRegWrite=0, enALU=1, isBranch=1. BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU. Immediate is B-format, sign-extended, bit0=0.
  - JAL (1101111): isJT=1, isJump=1, enRegWrite=1, enALU=0, useImmediate=0, opALU=0. Immediate is J-format.
  - JALR (1100111, fun3=000): isIT=1, isJump=1, enRegWrite=1, enALU=0, useImmediate=1, opALU=ADD.
  - EN_MEM=1 only:
    - LOAD (0000011): isIT=1, isLoad=1, enRegWrite=1, enALU=1, useImmediate=1, ADD.
    - STORE (0100011): isStore=1, enRegWrite=0, enALU=1, useImmediate=1, ADD; S-immediate.
    - LUI/AUIPC: enRegWrite=1, enALU=1, useImmediate=1, ADD; immediate = {[31:12],12'b0}.
  - Invalid opcode or invalid fun3/fun7: isVI=0 and every control, class and opALU output is 0. immediateValue=0. Raw fields, outPC and outInstruction still pass through. The entry still flows with outValid=1.

## Timing
- Reset (async, immediate): count=0, pointers=0, outValid=0, all decoded/control outputs and outPC/outInstruction=0, inReady=0 while rst is high.
- inReady=1 in the first cycle after rst deasserts.
- Latency: an instruction pushed at edge E into an empty queue with a free output stage has outValid=1 after edge E+1.
- Throughput: 1 instruction/cycle sustained with outReady held high.
- Output registers are held stable while outValid && !outReady.
- inReady is combinational from count, flush and rst only; it never depends on outReady.
- Reset asserted mid-stream: all contents are lost; there is no partial output.

## Test plan
- Reset then push ADD x1,x2,x3 (0x003100B3) at PC 0x100, outReady=1 → two edges later outValid=1, isRT=1, opALU=0000, enRegWrite=1, outPC=0x100; next cycle outValid=0.
- DEPTH=4, outReady=0, push 6 instructions → inReady falls after the 4th queued entry (plus one in the output stage), count=4. Raise outReady → 5 entries drain in order, one per cycle.
- Stream of SLTI -50 (0xFCE22193), BNE -16 (0xFE4198E3), JAL x1,1024 (0x400000EF), JALR x2,x3,16 (0x01018167) → immediates 0xFFFFFFCE, 0xFFFFFFF0, 0x400, 0x10 with the listed controls.
- Queue 3 entries, assert flush together with inValid and outReady → next cycle count=0, outValid=0, the offered instruction is not accepted, inReady=1.
- 0xFFFFFFFF, then LW 0x0000A083 with EN_MEM=0 → both isVI=0, controls 0, outValid=1. The same LW with EN_MEM=1 → isLoad=1, isVI=1.
- Assert rst while full and with outValid=1 → outputs are 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction queue between fetch and execute: buffers {instruction, PC} in a
// power-of-two FIFO and decodes the head entry into a registered output stage.
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter bit EN_MEM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     inValid_i,
    output logic                     inReady_o,
    input  logic [31:0]              inInstruction_i,
    input  logic [31:0]              inPC_i,
    output logic                     outValid_o,
    input  logic                     outReady_i,
    output logic [31:0]              outPC_o,
    output logic [31:0]              outInstruction_o,
    output logic [6:0]               opcode_o,
    output logic [4:0]               rd_o,
    output logic [4:0]               rs1_o,
    output logic [4:0]               rs2_o,
    output logic [2:0]               fun3_o,
    output logic [6:0]               fun7_o,
    output logic [31:0]              immediateValue_o,
    output logic                     enRegWrite_o,
    output logic                     enALU_o,
    output logic                     useImmediate_o,
    output logic                     isBranch_o,
    output logic                     isJump_o,
    output logic                     isLoad_o,
    output logic                     isStore_o,
    output logic [3:0]               opALU_o,
    output logic                     isRT_o,
    output logic                     isIT_o,
    output logic                     isBT_o,
    output logic                     isJT_o,
    output logic                     isVI_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  fun3;
        logic [6:0]  fun7;
        logic [31:0] imm;
        logic        en_reg_write;
        logic        en_alu;
        logic        use_imm;
        logic        is_branch;
        logic        is_jump;
        logic        is_load;
        logic        is_store;
        logic [3:0]  op_alu;
        logic        is_rt;
        logic        is_it;
        logic        is_bt;
        logic        is_jt;
        logic        is_vi;
    } dec_t;

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q;
    logic [31:0]   out_pc_q, out_instr_q;
    dec_t          dec_q, dec_d;

    logic        push, load;
    logic [31:0] ins, head_pc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alt, f7_zero;
    logic [3:0]  alu_f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inReady_o = !rst && !flush_i && (count_q < DEPTH_C);
    assign push      = inValid_i && inReady_o;
    assign load      = (count_q != '0) && (!out_valid_q || outReady_i) && !flush_i;

    // Storage array has no reset: contents are meaningless once count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {inInstruction_i, inPC_i};
        end
    end

    assign ins     = mem_q[rd_ptr_q][63:32];
    assign head_pc = mem_q[rd_ptr_q][31:0];
    assign f3      = ins[14:12];
    assign f7      = ins[31:25];
    assign alt     = (f7 == 7'b0100000);
    assign f7_zero = (f7 == 7'b0000000);

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    always_comb begin
        alu_f3 = 4'b0000;
        case (f3)
            3'b000: alu_f3 = 4'b0000;
            3'b001: alu_f3 = 4'b0111;
            3'b010: alu_f3 = 4'b0101;
            3'b011: alu_f3 = 4'b0110;
            3'b100: alu_f3 = 4'b0100;
            3'b101: alu_f3 = 4'b1000;
            3'b110: alu_f3 = 4'b0011;
            3'b111: alu_f3 = 4'b0010;
            default: alu_f3 = 4'b0000;
        endcase
    end

    // Anything not matched leaves controls, class, opALU and immediate at zero.
    always_comb begin
        dec_d = '0;
        case (ins[6:0])
            OP_R: begin
                if (f7_zero || (alt && (f3 == 3'b000 || f3 == 3'b101))) begin
                    dec_d.is_vi        = 1'b1;
                    dec_d.is_rt        = 1'b1;
                    dec_d.en_reg_write = 1'b1;
                    dec_d.en_alu       = 1'b1;
                    dec_d.op_alu       = alu_f3 | {3'b000, alt};
                end
            end
            OP_I: begin
                if ((f3 != 3'b001 || f7_zero) && (f3 != 3'b101 || f7_zero || alt)) begin
                    dec_d.is_vi        = 1'b1;
                    dec_d.is_it        = 1'b1;
                    dec_d.en_reg_write = 1'b1;
                    dec_d.en_alu       = 1'b1;
                    dec_d.use_imm      = 1'b1;
                    dec_d.op_alu       = alu_f3 | {3'b000, (f3 == 3'b101) && alt};
                    dec_d.imm          = imm_i;
                end
            end
            OP_B: begin
                if (f3 != 3'b010 && f3 != 3'b011) begin
                    dec_d.is_vi     = 1'b1;
                    dec_d.is_bt     = 1'b1;
                    dec_d.is_branch = 1'b1;
                    dec_d.en_alu    = 1'b1;
                    dec_d.imm       = imm_b;
                    case (f3[2:1])
                        2'b00:   dec_d.op_alu = 4'b0001;
                        2'b10:   dec_d.op_alu = 4'b0101;
                        default: dec_d.op_alu = 4'b0110;
                    endcase
                end
            end
            OP_JAL: begin
                dec_d.is_vi        = 1'b1;
                dec_d.is_jt        = 1'b1;
                dec_d.is_jump      = 1'b1;
                dec_d.en_reg_write = 1'b1;
                dec_d.imm          = imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    dec_d.is_vi        = 1'b1;
                    dec_d.is_it        = 1'b1;
                    dec_d.is_jump      = 1'b1;
                    dec_d.en_reg_write = 1'b1;
                    dec_d.use_imm      = 1'b1;
                    dec_d.imm          = imm_i;
                end
            end
            OP_LOAD: begin
                if (EN_MEM && f3 != 3'b011 && f3[2:1] != 2'b11) begin
                    dec_d.is_vi        = 1'b1;
                    dec_d.is_it        = 1'b1;
                    dec_d.is_load      = 1'b1;
                    dec_d.en_reg_write = 1'b1;
                    dec_d.en_alu       = 1'b1;
                    dec_d.use_imm      = 1'b1;
                    dec_d.imm          = imm_i;
                end
            end
            OP_STORE: begin
                if (EN_MEM && f3[2] == 1'b0 && f3 != 3'b011) begin
                    dec_d.is_vi    = 1'b1;
                    dec_d.is_store = 1'b1;
                    dec_d.en_alu   = 1'b1;
                    dec_d.use_imm  = 1'b1;
                    dec_d.imm      = imm_s;
                end
            end
            OP_LUI, OP_AUIPC: begin
                if (EN_MEM) begin
                    dec_d.is_vi        = 1'b1;
                    dec_d.en_reg_write = 1'b1;
                    dec_d.en_alu       = 1'b1;
                    dec_d.use_imm      = 1'b1;
                    dec_d.imm          = imm_u;
                end
            end
            default: dec_d.is_vi = 1'b0;
        endcase
        dec_d.opcode = ins[6:0];
        dec_d.rd     = ins[11:7];
        dec_d.rs1    = ins[19:15];
        dec_d.rs2    = ins[24:20];
        dec_d.fun3   = f3;
        dec_d.fun7   = f7;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (load) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, load})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            dec_q       <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (flush_i) begin
                out_valid_q <= 1'b0;
            end else if (load) begin
                out_valid_q <= 1'b1;
                out_pc_q    <= head_pc;
                out_instr_q <= ins;
                dec_q       <= dec_d;
            end else if (outReady_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign outValid_o       = out_valid_q;
    assign outPC_o          = out_pc_q;
    assign outInstruction_o = out_instr_q;
    assign count_o          = count_q;
    assign opcode_o         = dec_q.opcode;
    assign rd_o             = dec_q.rd;
    assign rs1_o            = dec_q.rs1;
    assign rs2_o            = dec_q.rs2;
    assign fun3_o           = dec_q.fun3;
    assign fun7_o           = dec_q.fun7;
    assign immediateValue_o = dec_q.imm;
    assign enRegWrite_o     = dec_q.en_reg_write;
    assign enALU_o          = dec_q.en_alu;
    assign useImmediate_o   = dec_q.use_imm;
    assign isBranch_o       = dec_q.is_branch;
    assign isJump_o         = dec_q.is_jump;
    assign isLoad_o         = dec_q.is_load;
    assign isStore_o        = dec_q.is_store;
    assign opALU_o          = dec_q.op_alu;
    assign isRT_o           = dec_q.is_rt;
    assign isIT_o           = dec_q.is_it;
    assign isBT_o           = dec_q.is_bt;
    assign isJT_o           = dec_q.is_jt;
    assign isVI_o           = dec_q.is_vi;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (EN_MEM=0 at index 0, EN_MEM=1 at index 1)
// share stimulus; a queue-level model is compared every cycle, plus literal checks.
module tb_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;

    logic        in_ready [2];
    logic        out_valid [2];
    logic [31:0] out_pc [2], out_instr [2], imm [2];
    logic [6:0]  opcode [2], fun7 [2];
    logic [4:0]  rd [2], rs1 [2], rs2 [2];
    logic [2:0]  fun3 [2];
    logic        en_rw [2], en_alu [2], use_imm [2], is_br [2], is_jmp [2], is_ld [2], is_st [2];
    logic [3:0]  op_alu [2];
    logic        is_rt [2], is_it [2], is_bt [2], is_jt [2], is_vi [2];
    logic [2:0]  count [2];
    logic [79:0] dut_vec [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        decode_queue #(.DEPTH(DEPTH), .EN_MEM(gi == 1)) u_dut (
            .clk(clk), .rst(rst), .flush_i(flush),
            .inValid_i(in_valid), .inReady_o(in_ready[gi]),
            .inInstruction_i(in_instr), .inPC_i(in_pc),
            .outValid_o(out_valid[gi]), .outReady_i(out_ready),
            .outPC_o(out_pc[gi]), .outInstruction_o(out_instr[gi]),
            .opcode_o(opcode[gi]), .rd_o(rd[gi]), .rs1_o(rs1[gi]), .rs2_o(rs2[gi]),
            .fun3_o(fun3[gi]), .fun7_o(fun7[gi]), .immediateValue_o(imm[gi]),
            .enRegWrite_o(en_rw[gi]), .enALU_o(en_alu[gi]), .useImmediate_o(use_imm[gi]),
            .isBranch_o(is_br[gi]), .isJump_o(is_jmp[gi]), .isLoad_o(is_ld[gi]),
            .isStore_o(is_st[gi]), .opALU_o(op_alu[gi]),
            .isRT_o(is_rt[gi]), .isIT_o(is_it[gi]), .isBT_o(is_bt[gi]), .isJT_o(is_jt[gi]),
            .isVI_o(is_vi[gi]), .count_o(count[gi])
        );
        assign dut_vec[gi] = {opcode[gi], rd[gi], rs1[gi], rs2[gi], fun3[gi], fun7[gi], imm[gi],
                              en_rw[gi], en_alu[gi], use_imm[gi], is_br[gi], is_jmp[gi],
                              is_ld[gi], is_st[gi], op_alu[gi],
                              is_rt[gi], is_it[gi], is_bt[gi], is_jt[gi], is_vi[gi]};
    end

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference decode written from the ISA tables: {wr,alu,imm,br,jmp,ld,st} and {rt,it,bt,jt,vi}.
    function automatic logic [79:0] ref_dec(input logic [31:0] x, input bit en_mem);
        logic [3:0]  alu_tab [8];
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [6:0]  ctl;
        logic [4:0]  cls;
        logic [3:0]  op;
        logic [31:0] iv;
        bit          ok, sub;
        alu_tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        opc = x[6:0]; f3 = x[14:12]; f7 = x[31:25];
        sub = (f7 == 7'h20);
        ok = 1'b0; ctl = '0; cls = '0; op = '0; iv = '0;
        case (opc)
            7'h33: begin
                ok = (f7 == 7'h00) || (sub && (f3 == 3'd0 || f3 == 3'd5));
                ctl = 7'b1100000; cls = 5'b10001; op = alu_tab[f3] + (sub ? 4'd1 : 4'd0);
            end
            7'h13: begin
                ok = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || sub) : 1'b1;
                ctl = 7'b1110000; cls = 5'b01001;
                op = alu_tab[f3] + ((f3 == 3'd5 && sub) ? 4'd1 : 4'd0);
                iv = 32'($signed(x[31:20]));
            end
            7'h63: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                ctl = 7'b0101000; cls = 5'b00101;
                op = (f3 < 3'd4) ? 4'd1 : (f3 < 3'd6) ? 4'd5 : 4'd6;
                iv = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
            end
            7'h6F: begin
                ok = 1'b1; ctl = 7'b1000100; cls = 5'b00011;
                iv = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
            end
            7'h67: begin
                ok = (f3 == 3'd0); ctl = 7'b1010100; cls = 5'b01001;
                iv = 32'($signed(x[31:20]));
            end
            7'h03: begin
                ok = en_mem && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                ctl = 7'b1110010; cls = 5'b01001; iv = 32'($signed(x[31:20]));
            end
            7'h23: begin
                ok = en_mem && (f3 < 3'd3);
                ctl = 7'b0110001; cls = 5'b00001; iv = 32'($signed({x[31:25], x[11:7]}));
            end
            7'h37, 7'h17: begin
                ok = en_mem; ctl = 7'b1110000; cls = 5'b00001; iv = {x[31:12], 12'h000};
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin ctl = '0; cls = '0; op = '0; iv = '0; end
        return {opc, x[11:7], x[19:15], x[24:20], f3, f7, iv, ctl, op, cls};
    endfunction

    // Queue-level model: pending entries plus the one in the output stage.
    logic [63:0] mq [$];
    logic [63:0] m_entry = '0;
    bit          m_valid = 1'b0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete(); m_valid = 1'b0; m_entry = '0;
        end else if (flush) begin
            mq.delete(); m_valid = 1'b0;
        end else begin
            bit p, l;
            p = in_valid && (mq.size() < DEPTH);
            l = (mq.size() != 0) && (!m_valid || out_ready);
            if (l) begin m_entry = mq.pop_front(); m_valid = 1'b1; end
            else if (out_ready) m_valid = 1'b0;
            if (p) mq.push_back({in_instr, in_pc});
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            chk("inReady", in_ready[g], !rst && !flush && (mq.size() < DEPTH));
            chk("count", count[g], mq.size());
            chk("outValid", out_valid[g], m_valid);
            if (m_valid || rst) begin
                chk("outPC", out_pc[g], m_entry[31:0]);
                chk("outInstruction", out_instr[g], m_entry[63:32]);
                chk("decode", dut_vec[g], ref_dec(m_entry[63:32], g == 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s_ins [4]  = '{32'hFCE22193, 32'hFE4198E3, 32'h400000EF, 32'h01018167};
    logic [31:0] s_imm [4]  = '{32'hFFFFFFCE, 32'hFFFFFFF0, 32'h00000400, 32'h00000010};
    logic [6:0]  s_ctl [4]  = '{7'b1110000, 7'b0101000, 7'b1000100, 7'b1010100};
    logic [3:0]  s_op  [4]  = '{4'b0101, 4'b0001, 4'b0000, 4'b0000};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        tick(); tick();
        chk("rst_inReady", in_ready[1], 1'b0);
        chk("rst_outValid", out_valid[1], 1'b0);
        chk("rst_count", count[1], 3'd0);
        rst = 1'b0;
        #1 chk("post_rst_inReady", in_ready[1], 1'b1);

        // ADD x1,x2,x3 single-instruction latency
        in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h100; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("add_outValid", out_valid[1], 1'b1);
        chk("add_isRT", is_rt[1], 1'b1);
        chk("add_opALU", op_alu[1], 4'b0000);
        chk("add_enRegWrite", en_rw[1], 1'b1);
        chk("add_outPC", out_pc[1], 32'h100);
        $display("txn add: outValid=%0d isRT=%0d opALU=%0h pc=%0h", out_valid[1], is_rt[1], op_alu[1], out_pc[1]);
        tick();
        chk("add_drain", out_valid[1], 1'b0);

        // Fill with consumer stalled: four queued plus one in output stage
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = {12'(i), 5'd0, 3'd0, 5'd1, 7'h13}; in_pc = 32'h200 + 32'(4 * i);
            if (i == 5) begin
                chk("full_inReady", in_ready[1], 1'b0);
                chk("full_count", count[1], 3'd4);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("drain0_pc", out_pc[1], 32'h200);
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("drain_pc", out_pc[1], 32'h200 + 32'(4 * k));
            $display("txn drain %0d: pc=%0h count=%0d", k, out_pc[1], count[1]);
        end
        tick();
        chk("drain_done", out_valid[1], 1'b0);

        // Back-to-back immediates and controls
        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                in_valid = 1'b1; in_instr = s_ins[t]; in_pc = 32'h300 + 32'(4 * t);
            end else in_valid = 1'b0;
            tick();
            if (t >= 1 && t <= 4) begin
                chk("stream_imm", imm[1], s_imm[t-1]);
                chk("stream_ctl", {en_rw[1], en_alu[1], use_imm[1], is_br[1], is_jmp[1], is_ld[1], is_st[1]}, s_ctl[t-1]);
                chk("stream_op", op_alu[1], s_op[t-1]);
                $display("txn stream %0d: ins=%h imm=%h opALU=%0h", t-1, out_instr[1], imm[1], op_alu[1]);
            end
        end
        chk("stream_done", out_valid[1], 1'b0);

        // Flush with offered instruction and consumer ready
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h400 + 32'(4 * i);
            tick();
        end
        chk("preflush_count", count[1], 3'd3);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h00000013;
        #1 chk("flush_inReady", in_ready[1], 1'b0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_count", count[1], 3'd0);
        chk("flush_outValid", out_valid[1], 1'b0);
        chk("flush_inReady_after", in_ready[1], 1'b1);
        $display("txn flush: count=%0d outValid=%0d", count[1], out_valid[1]);
        tick();
        chk("flush_not_taken", count[1], 3'd0);

        // Invalid opcode, then LW with and without memory decode
        in_valid = 1'b1; in_instr = 32'hFFFFFFFF; in_pc = 32'h500;
        tick();
        in_instr = 32'h0000A083; in_pc = 32'h504;
        tick();
        in_valid = 1'b0;
        chk("ones_outValid", out_valid[0], 1'b1);
        chk("ones_isVI0", is_vi[0], 1'b0);
        chk("ones_isVI1", is_vi[1], 1'b0);
        chk("ones_ctl", {en_rw[1], en_alu[1], use_imm[1], op_alu[1], imm[1]}, 39'd0);
        chk("ones_instr", out_instr[1], 32'hFFFFFFFF);
        tick();
        chk("lw_nomem_outValid", out_valid[0], 1'b1);
        chk("lw_nomem_isVI", is_vi[0], 1'b0);
        chk("lw_nomem_ctl", {en_rw[0], is_ld[0], is_it[0]}, 3'b000);
        chk("lw_mem_isLoad", is_ld[1], 1'b1);
        chk("lw_mem_isVI", is_vi[1], 1'b1);
        chk("lw_mem_ctl", {en_rw[1], en_alu[1], use_imm[1], is_it[1], op_alu[1], rd[1]}, {4'b1111, 4'b0000, 5'd1});
        $display("txn lw: nomem isVI=%0d mem isVI=%0d isLoad=%0d", is_vi[0], is_vi[1], is_ld[1]);
        tick();

        // Asynchronous reset while full with a valid output
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 32'h003100B3; in_pc = 32'h600 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0;
        chk("prerst_full", {out_valid[1], count[1]}, {1'b1, 3'd4});
        rst = 1'b1;
        #1;
        chk("arst_outValid", out_valid[1], 1'b0);
        chk("arst_count", count[1], 3'd0);
        chk("arst_inReady", in_ready[1], 1'b0);
        chk("arst_outPC", out_pc[1], 32'h0);
        chk("arst_fields", {opcode[1], is_rt[1], en_rw[1], is_vi[1]}, 10'd0);
        $display("txn async reset: outValid=%0d count=%0d pc=%0h", out_valid[1], count[1], out_pc[1]);
        tick();
        rst = 1'b0;
        #1 chk("rst_release_inReady", in_ready[1], 1'b1);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
